// File: rtl/prog_chain_loader_if.sv
// prog_chain_loader_if
//   Word stream carrying the configuration bitstream into prog_chain_loader.
//   Parameter: WORD_W - width of one bitstream word.
//   Signals:
//     s_data  - bitstream word, bit 0 is shifted onto the chain first
//     s_valid - s_data holds a word
//     s_ready - the loader takes a word this cycle
//   Handshake: a word moves on a rising clk edge where s_valid and s_ready are
//   both 1. Once s_valid is raised, the master holds it and s_data steady until
//   that edge. s_ready never depends on s_valid in the same cycle.
//   Modports: master (word source), slave (the loader).
interface prog_chain_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/prog_chain_loader.sv
// prog_chain_loader
//   Takes the configuration bitstream as WORD_W-bit words and shifts it LSB
//   first onto the FPGA configuration chain. The divided shift clock is
//   produced here. Each bit takes CLK_DIV cycles with prog_clk low (SETUP),
//   then CLK_DIV cycles with prog_clk high (HIGH). After CHAIN_LEN bits the
//   load ends, and any unused upper bits of the last word are dropped.
//   Optional feature (macro PROG_READBACK_CRC_EN): CRC-16-CCITT over the old
//   chain contents read back on prog_out. Without the macro, crc_out is 0.
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   start          one-cycle load request, acted on only in IDLE
//   abort          ends a load in progress at once, takes priority
//   s_if           word stream (slave side)
//   prog_in        serial data to the chain
//   prog_clk       chain shift clock
//   prog_en        chain shift enable
//   prog_out       chain tail (old contents)
//   busy           a load is in progress
//   done           one-cycle pulse when a load completes normally
//   aborted        sticky flag: the last load was aborted
//   bit_count      bits shifted in the current or last load
//   crc_out        readback CRC (0 when the feature is not built)
//   dbg_state      current FSM state
module prog_chain_loader #(
  parameter int CHAIN_LEN = 1480,
  parameter int WORD_W    = 32,
  parameter int CLK_DIV   = 2,
  parameter int CNT_W     = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  prog_chain_loader_if.slave s_if,
  output logic               prog_in,
  output logic               prog_clk,
  output logic               prog_en,
  input  logic               prog_out,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [CNT_W-1:0]   bit_count,
  output logic [15:0]        crc_out,
  output logic [2:0]         dbg_state
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_WORD = 3'd1,
    S_SETUP     = 3'd2,
    S_HIGH      = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               aborted_q, aborted_d;
  logic               prog_clk_q, prog_clk_d;
  logic               phase_end;

  // Last cycle of a SETUP or HIGH half-period.
  assign phase_end = (div_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    idx_d     = idx_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    aborted_d = aborted_q;
    if (state_q != S_IDLE && abort) begin
      // A word offered in the same cycle is not loaded.
      state_d   = S_IDLE;
      aborted_d = 1'b1;
      div_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_WAIT_WORD;
            cnt_d     = '0;
            aborted_d = 1'b0;
          end
        end
        S_WAIT_WORD: begin
          if (s_if.s_valid) begin
            word_d  = s_if.s_data;
            idx_d   = '0;
            div_d   = '0;
            state_d = S_SETUP;
          end
        end
        S_SETUP: begin
          if (phase_end) begin
            div_d   = '0;
            cnt_d   = cnt_q + 1'b1;
            state_d = S_HIGH;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        S_HIGH: begin
          if (phase_end) begin
            div_d = '0;
            if (cnt_q == CNT_W'(CHAIN_LEN)) begin
              state_d = S_DONE;
            end else if (idx_q == IDX_W'(WORD_W - 1)) begin
              state_d = S_WAIT_WORD;
            end else begin
              // The next bit moves into word_q[0], which drives prog_in.
              idx_d   = idx_q + 1'b1;
              word_d  = word_q >> 1;
              state_d = S_SETUP;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    // prog_clk is registered so the chain clock has no decode glitches.
    prog_clk_d = (state_d == S_HIGH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      idx_q      <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      aborted_q  <= 1'b0;
      prog_clk_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      aborted_q  <= aborted_d;
      prog_clk_q <= prog_clk_d;
    end
  end

  assign s_if.s_ready = (state_q == S_WAIT_WORD);
  assign busy         = (state_q == S_WAIT_WORD) || (state_q == S_SETUP) || (state_q == S_HIGH);
  assign prog_en      = busy;
  assign prog_clk     = prog_clk_q;
  assign prog_in      = ((state_q == S_SETUP) || (state_q == S_HIGH)) && word_q[0];
  assign done         = (state_q == S_DONE);
  assign aborted      = aborted_q;
  assign bit_count    = cnt_q;
  assign dbg_state    = state_q;

`ifdef PROG_READBACK_CRC_EN
  logic [15:0] crc_q, crc_d;

  // prog_out is read in the last SETUP cycle, while the bit about to leave the
  // chain is still at the tail.
  always_comb begin
    crc_d = crc_q;
    if (state_q == S_IDLE && start) begin
      crc_d = 16'hFFFF;
    end else if (state_q == S_SETUP && phase_end && !abort) begin
      crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ prog_out) ? 16'h1021 : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= 16'h0000;
    else        crc_q <= crc_d;
  end

  assign crc_out = crc_q;
`else
  logic unused_prog_out;
  assign unused_prog_out = prog_out;
  assign crc_out         = 16'h0000;
`endif

endmodule
